// File: rtl/lsu_ctrl_if.sv
// Signal bundle around lsu_ctrl: EX request handshake, data-memory port and WB result handshake.
// master is the load/store unit itself; slave is the EX/memory/WB environment it talks to.
interface lsu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;

    logic [63:0] mem_addr;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_err;

    modport master (
        input  in_valid, in_is_store, in_size, in_unsigned, in_addr, in_wdata,
        input  mem_rdata, out_ready,
        output in_ready, mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask,
        output out_valid, out_rdata, out_err
    );

    modport slave (
        output in_valid, in_is_store, in_size, in_unsigned, in_addr, in_wdata,
        output mem_rdata, out_ready,
        input  in_ready, mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask,
        input  out_valid, out_rdata, out_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller in front of a combinational 64-bit data memory.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] word_q, word_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        ce_q, ce_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic [63:0] rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        err_q, err_d;
`endif

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0f;
            default: m = 8'hff;
        endcase
        return m;
    endfunction

    // Bytes shifted past lane 7 fall off the top; missing upper bytes read as zero.
    function automatic logic [63:0] load_ext(input logic [63:0] word, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   res = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'b01:   res = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'b10:   res = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic m;
        case (size)
            2'b01:   m = off[0];
            2'b10:   m = |off[1:0];
            2'b11:   m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        ce_d    = ce_q;
        we_d    = we_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    store_d = bus.in_is_store;
                    size_d  = bus.in_size;
                    uns_d   = bus.in_unsigned;
                    off_d   = bus.in_addr[2:0];
                    rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(bus.in_size, bus.in_addr[2:0])) begin
                        state_d = StDone;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = StReq;
                        ce_d    = 1'b1;
                        we_d    = bus.in_is_store;
                        addr_d  = {bus.in_addr[63:3], 3'b000};
                        wmask_d = bus.in_is_store ? base_mask(bus.in_size) << bus.in_addr[2:0]
                                                  : 8'h00;
                        wdata_d = bus.in_is_store ? bus.in_wdata << {bus.in_addr[2:0], 3'b000}
                                                  : 64'h0;
                    end
                end
            end
            StReq: begin
                ce_d    = 1'b0;
                we_d    = 1'b0;
                wmask_d = 8'h00;
                if (!store_q) begin
                    word_d = bus.mem_rdata;
                end
                if (MEM_LAT == 0) begin
                    // No wait phase: extract straight from the live memory word.
                    state_d = StDone;
                    valid_d = 1'b1;
                    rdata_d = store_q ? 64'h0 : load_ext(bus.mem_rdata, off_q, size_q, uns_q);
                end else begin
                    state_d = StWait;
                    cnt_d   = 4'(MEM_LAT);
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    rdata_d = store_q ? 64'h0 : load_ext(word_q, off_q, size_q, uns_q);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 3'b000;
            word_q  <= 64'h0;
            cnt_q   <= 4'd0;
            addr_q  <= 64'h0;
            wdata_q <= 64'h0;
            wmask_q <= 8'h00;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 64'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_ce    = ce_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.out_valid = valid_q;
    assign bus.out_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.out_err   = err_q;
`else
    assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed loads/stores, backpressure and mid-access reset.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trap vectors instead of wrap-around ones.
module tb_lsu_ctrl;
    localparam int unsigned MEM_LAT = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } out_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  mask;
        logic [63:0] wdata;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] mem_word = 64'h0;
    int          nvec = 0;
    int          nmis = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    out_t        exp_q[$];
    mem_t        mem_q[$];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem_word;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) acc_cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops one expectation per rising out_valid.
    initial begin
        logic prev_v;
        out_t o;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (bus.out_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                    end else begin
                        o = exp_q.pop_front();
                        chk("out_rdata", bus.out_rdata, o.rdata);
                        chk("out_err", 64'(bus.out_err), 64'(o.err));
                        chk("latency", 64'(cyc - acc_cyc), 64'(o.lat));
                    end
                end
                prev_v = bus.out_valid;
            end
        end
    end

    // Memory-port monitor: every mem_ce cycle must match a queued access and last one cycle.
    initial begin
        logic prev_ce;
        mem_t m;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_ce) begin
                chk("ce_single_cycle", 64'(prev_ce), 64'd0);
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_ce", 64'(bus.mem_ce), 64'd0);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_addr", bus.mem_addr, m.addr);
                    chk("mem_we", 64'(bus.mem_we), 64'(m.we));
                    if (m.we) begin
                        chk("mem_wmask", 64'(bus.mem_wmask), 64'(m.mask));
                        chk("mem_wdata", bus.mem_wdata, m.wdata);
                    end
                end
            end
            prev_ce = bus.mem_ce;
        end
    end

    // Issues one request; expectations go to the scoreboard before the accepting edge.
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] word,
                         input logic [63:0] exp_rd, input logic [7:0] exp_mask,
                         input logic [63:0] exp_wd, input logic exp_err);
        out_t o;
        mem_t m;
        o.rdata = exp_rd;
        o.err   = exp_err;
        o.lat   = exp_err ? 1 : int'(MEM_LAT) + 1;
        exp_q.push_back(o);
        if (!exp_err) begin
            m.addr  = {addr[63:3], 3'b000};
            m.we    = st;
            m.mask  = exp_mask;
            m.wdata = exp_wd;
            mem_q.push_back(m);
        end
        @(negedge clk);
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_is_store = st;
        bus.in_size     = sz;
        bus.in_unsigned = uns;
        bus.in_addr     = addr;
        bus.in_wdata    = wd;
        mem_word        = word;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic finish_txn();
        int i;
        i = 0;
        while (!bus.out_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        end else if (bus.out_ready) begin
            @(posedge clk);
            @(negedge clk);
            chk("out_valid_cleared", 64'(bus.out_valid), 64'd0);
            chk("back_to_idle", 64'(bus.in_ready), 64'd1);
        end
    endtask

    task automatic txn(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] word,
                       input logic [63:0] exp_rd, input logic [7:0] exp_mask,
                       input logic [63:0] exp_wd, input logic exp_err);
        issue(st, sz, uns, addr, wd, word, exp_rd, exp_mask, exp_wd, exp_err);
        finish_txn();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_is_store = 1'b0;
        bus.in_size     = 2'b00;
        bus.in_unsigned = 1'b0;
        bus.in_addr     = 64'h0;
        bus.in_wdata    = 64'h0;
        bus.out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_mem_ce", 64'(bus.mem_ce), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'h0);
        chk("rst_mem_wmask", 64'(bus.mem_wmask), 64'h0);
        chk("rst_out_rdata", bus.out_rdata, 64'h0);
        rst_n = 1'b1;

        //  st    size  uns   addr            wdata                word                 exp_rdata            mask   exp_wdata         err
        txn(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hab,             64'h0,               64'h0,               8'h08, 64'h0000_0000_ab00_0000, 1'b0);
        txn(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0,              64'h0000_0000_ab00_0000, 64'hffff_ffff_ffff_ffab, 8'h00, 64'h0, 1'b0);
        txn(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0,              64'h0000_0000_ab00_0000, 64'h0000_0000_0000_00ab, 8'h00, 64'h0, 1'b0);
        txn(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'h0,              64'h8765_4321_0000_0000, 64'h0000_0000_0000_8765, 8'h00, 64'h0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0,              64'h8765_4321_0000_0000, 64'hffff_ffff_8765_4321, 8'h00, 64'h0, 1'b0);
        txn(1'b1, 2'd1, 1'b0, 64'h8000_0012, 64'hbeef,           64'h0,               64'h0,               8'h0c, 64'h0000_0000_beef_0000, 1'b0);
        txn(1'b1, 2'd3, 1'b0, 64'h8000_0020, 64'h0123_4567_89ab_cdef, 64'h0,          64'h0,               8'hff, 64'h0123_4567_89ab_cdef, 1'b0);
        txn(1'b0, 2'd3, 1'b0, 64'h8000_0028, 64'h0,              64'hfedc_ba98_7654_3210, 64'hfedc_ba98_7654_3210, 8'h00, 64'h0, 1'b0);
        txn(1'b0, 2'd1, 1'b0, 64'h8000_0000, 64'h0,              64'h0000_0000_0000_7fff, 64'h0000_0000_0000_7fff, 8'h00, 64'h0, 1'b0);
        txn(1'b0, 2'd0, 1'b0, 64'h8000_0007, 64'h0,              64'h8000_0000_0000_0000, 64'hffff_ffff_ffff_ff80, 8'h00, 64'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        txn(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0,              64'h1111_2222_3333_4444, 64'h0, 8'h00, 64'h0, 1'b1);
        txn(1'b1, 2'd1, 1'b0, 64'h8000_0001, 64'h5555,           64'h0,               64'h0, 8'h00, 64'h0, 1'b1);
        txn(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0,              64'h1111_2222_3333_4444, 64'h0, 8'h00, 64'h0, 1'b1);
        txn(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0,              64'h9999_8888_0000_0000, 64'h0000_0000_9999_8888, 8'h00, 64'h0, 1'b0);
`else
        txn(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hdead_beef,      64'h0,               64'h0,               8'hc0, 64'hbeef_0000_0000_0000, 1'b0);
        txn(1'b0, 2'd3, 1'b0, 64'h8000_0003, 64'h0,              64'h1122_3344_5566_7788, 64'h0000_0011_2233_4455, 8'h00, 64'h0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 64'h8000_0005, 64'h0,              64'h8877_6655_4433_2211, 64'h0000_0000_0088_7766, 8'h00, 64'h0, 1'b0);
`endif

        // Backpressure: hold DONE for five cycles while EX keeps poking in_valid.
        bus.out_ready = 1'b0;
        txn(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_ab00_0000,
            64'hffff_ffff_ffff_ffab, 8'h00, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_rdata", bus.out_rdata, 64'hffff_ffff_ffff_ffab);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_is_store = 1'b1;
            bus.in_addr     = 64'h8000_0100;
            bus.in_valid    = (i % 2 == 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_idle", 64'(bus.in_ready), 64'd1);

        // Reset while a store sits in WAIT, with in_valid held during reset.
        issue(1'b1, 2'd2, 1'b0, 64'h8000_0040, 64'h1234_5678, 64'h0, 64'h0, 8'h0f,
              64'h0000_0000_1234_5678, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_mem_ce", 64'(bus.mem_ce), 64'd0);
        chk("rst_async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_async_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        bus.in_is_store = 1'b0;
        bus.in_addr     = 64'h8000_0000;
        bus.in_valid    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_mem_ce", 64'(bus.mem_ce), 64'd0);
            chk("rst_hold_out_valid", 64'(bus.out_valid), 64'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'h0, 64'hffee_ddcc_8899_aabb,
            64'hffff_ffff_8899_aabb, 8'h00, 64'h0, 1'b0);

        repeat (4) @(negedge clk);
        chk("out_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control unit directly upstream of the DPI-backed data memory block (combinational 64-bit port: addr, we, ce, wdata, wmask, rdata).
- Accepts one load/store from EX over a valid/ready handshake and drives the memory port for exactly one cycle per access.
- Aligns store data and byte mask, then extracts and sign/zero-extends load data.
- Returns the result to WB over a valid/ready handshake.

Parameters:
- MEM_LAT, 2, extra wait cycles after the memory access before the result is presented; range 0..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  EX request valid
- in_ready  out  1  LSU can accept; equals (state==IDLE)
- in_is_store  in  1  1=store, 0=load
- in_size  in  2  00 byte, 01 half, 10 word, 11 double
- in_unsigned  in  1  load zero-extend when 1; ignored for stores
- in_addr  in  64  byte address
- in_wdata  in  64  store data, right-justified
- mem_addr  out  64  {addr[63:3],3'b0}
- mem_ce  out  1  memory enable, one-cycle pulse
- mem_we  out  1  write enable, only with mem_ce
- mem_wdata  out  64  store data shifted to lane
- mem_wmask  out  8  byte lane mask
- mem_rdata  in  64  combinational read data from memory block
- out_valid  out  1  result valid to WB
- out_ready  in  1  WB accepts
- out_rdata  out  64  extended load data; 0 for stores
- out_err  out  1  misaligned access flag

Behaviour:
- Reset (async, rst_n low): state=IDLE; mem_ce, mem_we, out_valid, out_err = 0; mem_addr, mem_wdata, mem_wmask, out_rdata = 0; wait counter = 0. While rst_n is low, mem_ce drops immediately and in_valid is ignored.
- Address offset: off = in_addr[2:0].
- Store mask: base mask = 0x01, 0x03, 0x0F, 0xFF by size; mem_wmask = base << off. mem_wdata = in_wdata << (8*off), truncated to 64 bits.
- Load extraction: sh = captured word >> (8*off), low 8/16/32/64 bits taken by size. Sign-extend from the top bit unless in_unsigned; double is never extended.
- States:
  - IDLE: in_ready=1. On in_valid, capture op/size/unsigned/offset.
    - If misaligned (see Optional Feature): go to DONE with out_err=1; memory port stays idle.
    - Else: register mem_* outputs, set mem_ce=1 (and mem_we=in_is_store), go to REQ.
  - REQ: exactly one cycle with mem_ce high. At the closing edge:
    - load: capture mem_rdata;
    - clear mem_ce/mem_we and mem_wmask;
    - go to WAIT with counter=MEM_LAT, or straight to DONE if MEM_LAT=0.
  - WAIT: decrement counter each cycle; go to DONE when counter==1.
  - DONE: out_valid=1; out_rdata/out_err held stable. On out_ready, clear out_valid/out_err and return to IDLE. A new request is accepted no earlier than the following cycle.
- Latency: out_valid rises MEM_LAT+1 edges after the accepting edge.
- out_rdata=0 for stores and errored accesses.
- Backpressure: in DONE with out_ready=0, all outputs hold and in_ready=0.
- Only one access is outstanding; no pipelining.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - An access is misaligned when off is not a multiple of the size (half: off[0]; word: off[1:0]; double: off!=0).
  - A misaligned access skips REQ/WAIT, never pulses mem_ce, and reaches DONE on the edge after acceptance with out_err=1.
- Not defined:
  - out_err is tied 0 and no alignment check is made.
  - Bytes shifted beyond lane 7 are dropped from both mask and data.
  - Load bytes beyond the 8-byte word read as 0 before extension.

Test Plan:
- Store byte 0xAB at 0x8000_0003 -> one-cycle mem_ce=1, mem_we=1, mem_addr=0x8000_0000, mem_wmask=0x08, mem_wdata=0x0000_0000_AB00_0000; out_valid 3 edges after accept (MEM_LAT=2), out_rdata=0.
- Signed byte load at 0x8000_0003, memory word 0x0000_0000_AB00_0000 -> out_rdata=0xFFFF_FFFF_FFFF_FFAB; unsigned -> 0x0000_0000_0000_00AB.
- Unsigned half at 0x8000_0006, word 0x8765_4321_0000_0000 -> 0x0000_0000_0000_8765. Signed word at 0x8000_0004 -> 0xFFFF_FFFF_8765_4321.
- With LSU_MISALIGN_TRAP_EN, load word at 0x8000_0002 -> mem_ce never high, out_valid=1 and out_err=1 one edge after accept, out_rdata=0.
- out_ready=0 for 5 cycles in DONE -> out_valid/out_rdata stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
- rst_n low during WAIT of a store -> mem_ce=0 and out_valid=0 immediately; after release, a load to 0x8000_0000 completes normally with correct data.
